// File: rtl/jtag_shift_pkg.sv
// Shared types and width helpers for the JTAG shift engine.
// Default widths describe the standard 64-bit, two-chain build.
package jtag_shift_pkg;

  localparam int unsigned JTAG_MAX_BITS = 64;
  localparam int unsigned JTAG_CHAINS   = 2;

  // Width of a select/index into n items, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LEN_W   = $clog2(JTAG_MAX_BITS + 1);
  localparam int unsigned CHAIN_W = sel_width(JTAG_CHAINS);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_RESP
  } jtag_state_e;

  typedef struct packed {
    logic [JTAG_MAX_BITS-1:0] tms;
    logic [JTAG_MAX_BITS-1:0] tdi;
    logic [LEN_W-1:0]         len;
    logic [CHAIN_W-1:0]       chain;
  } jtag_cmd_t;

endpackage

// File: rtl/jtag_shift_if.sv
// Host-side command/response port of the JTAG shift engine.
// master = debug transport, slave = engine.
interface jtag_shift_if #(
  parameter int unsigned MAX_BITS = 64,
  parameter int unsigned CHAINS   = 2
);
  import jtag_shift_pkg::*;

  localparam int unsigned LW = $clog2(MAX_BITS + 1);
  localparam int unsigned CW = sel_width(CHAINS);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [MAX_BITS-1:0] cmd_tms;
  logic [MAX_BITS-1:0] cmd_tdi;
  logic [LW-1:0]       cmd_len;
  logic [CW-1:0]       cmd_chain;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                rsp_aborted;

  modport master (
    output cmd_valid, cmd_tms, cmd_tdi, cmd_len, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo, rsp_aborted
  );

  modport slave (
    input  cmd_valid, cmd_tms, cmd_tdi, cmd_len, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo, rsp_aborted
  );

endinterface

// File: rtl/jtag_shift_engine_tck_div.sv
// TCK half-period timer: reloads on start, flags the last clk cycle of a phase.
module jtag_tck_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic phase_done
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_done = (cnt_q == '0);

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master executing whole TMS/TDI shift commands on one of CHAINS chains.
// Optional JTAG_SHIFT_LOOPBACK_EN adds a `loopback` input feeding TDI back as TDO.
module jtag_shift_engine
  import jtag_shift_pkg::*;
#(
  parameter int unsigned MAX_BITS = JTAG_MAX_BITS,
  parameter int unsigned CHAINS   = JTAG_CHAINS,
  parameter int unsigned DIV      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              init_done,
`ifdef JTAG_SHIFT_LOOPBACK_EN
  input  logic              loopback,
`endif
  jtag_shift_if.slave       host,
  output logic [CHAINS-1:0] jtag_TCK,
  output logic              jtag_TMS,
  output logic              jtag_TDI,
  output logic              jtag_TRST,
  input  logic [CHAINS-1:0] jtag_TDO,
  output logic              busy
);

  localparam int unsigned LW = $clog2(MAX_BITS + 1);
  localparam int unsigned CW = sel_width(CHAINS);
  localparam int unsigned IW = sel_width(MAX_BITS);

  jtag_state_e         state_q, state_d;
  logic [MAX_BITS-1:0] tms_vec_q, tms_vec_d;
  logic [MAX_BITS-1:0] tdi_vec_q, tdi_vec_d;
  logic [MAX_BITS-1:0] tdo_q, tdo_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       chain_q, chain_d;
  logic [CHAINS-1:0]   tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                trst_q, trst_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;

  logic                run;
  logic                phase_start;
  logic                phase_done;
  logic [LW-1:0]       len_sat;
  logic [CW-1:0]       chain_sel;
  logic [LW-1:0]       idx_inc;
  logic [CHAINS-1:0]   tck_sel;
  logic                tdo_bit;

  assign run       = enable & init_done;
  assign len_sat   = (host.cmd_len > LW'(MAX_BITS)) ? LW'(MAX_BITS) : host.cmd_len;
  assign chain_sel = (32'(host.cmd_chain) >= CHAINS) ? '0 : host.cmd_chain;
  assign idx_inc   = idx_q + LW'(1);
  assign tck_sel   = CHAINS'(1) << chain_q;

  // TDO is registered on the same clk edge that raises TCK, i.e. the
  // value the target presented during the preceding low phase.
`ifdef JTAG_SHIFT_LOOPBACK_EN
  assign tdo_bit = loopback ? tdi_q : jtag_TDO[chain_q];
`else
  assign tdo_bit = jtag_TDO[chain_q];
`endif

  jtag_tck_div #(
    .DIV (DIV)
  ) u_tck_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (phase_start),
    .phase_done (phase_done)
  );

  always_comb begin
    state_d     = state_q;
    tms_vec_d   = tms_vec_q;
    tdi_vec_d   = tdi_vec_q;
    tdo_d       = tdo_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chain_d     = chain_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    aborted_d   = aborted_q;
    phase_start = 1'b0;

    unique case (state_q)
      S_DISABLED: begin
        tck_d       = '0;
        trst_d      = 1'b1;
        cmd_ready_d = 1'b0;
        if (run) begin
          state_d     = S_IDLE;
          trst_d      = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      S_IDLE: begin
        // A handshake already visible to the host must be honoured even if
        // run drops in the same cycle; the shift then aborts on the next edge.
        if (host.cmd_valid && cmd_ready_q) begin
          tms_vec_d   = host.cmd_tms;
          tdi_vec_d   = host.cmd_tdi;
          len_d       = len_sat;
          chain_d     = chain_sel;
          tdo_d       = '0;
          idx_d       = '0;
          aborted_d   = 1'b0;
          cmd_ready_d = 1'b0;
          if (len_sat == '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d     = S_LOW;
            phase_start = 1'b1;
            tms_d       = host.cmd_tms[0];
            tdi_d       = host.cmd_tdi[0];
          end
        end else if (!run) begin
          state_d     = S_DISABLED;
          trst_d      = 1'b1;
          cmd_ready_d = 1'b0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      S_LOW, S_HIGH: begin
        if (!run) begin
          state_d     = S_RESP;
          tck_d       = '0;
          trst_d      = 1'b1;
          rsp_valid_d = 1'b1;
          aborted_d   = 1'b1;
        end else if (phase_done) begin
          if (state_q == S_LOW) begin
            state_d                = S_HIGH;
            phase_start            = 1'b1;
            tck_d                  = tck_sel;
            tdo_d[idx_q[IW-1:0]]   = tdo_bit;
          end else begin
            tck_d = '0;
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
            end else begin
              state_d     = S_LOW;
              phase_start = 1'b1;
              tms_d       = tms_vec_q[idx_inc[IW-1:0]];
              tdi_d       = tdi_vec_q[idx_inc[IW-1:0]];
            end
          end
        end
      end

      S_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (run) begin
            state_d     = S_IDLE;
            trst_d      = 1'b0;
            cmd_ready_d = 1'b1;
          end else begin
            state_d = S_DISABLED;
            trst_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_DISABLED;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DISABLED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_DISABLED;
      tms_vec_q   <= '0;
      tdi_vec_q   <= '0;
      tdo_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chain_q     <= '0;
      tck_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tms_vec_q   <= tms_vec_d;
      tdi_vec_q   <= tdi_vec_d;
      tdo_q       <= tdo_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chain_q     <= chain_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
    end
  end

  assign jtag_TCK         = tck_q;
  assign jtag_TMS         = tms_q;
  assign jtag_TDI         = tdi_q;
  assign jtag_TRST        = trst_q;
  assign busy             = busy_q;
  assign host.cmd_ready   = cmd_ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_tdo     = tdo_q;
  assign host.rsp_aborted = aborted_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed self-checking bench for jtag_shift_engine (MAX_BITS=64, CHAINS=2, DIV=2).
// Chain 1 TDO follows TDI, chain 0 TDO follows inverted TDI (both updated on clk fall).
module tb_jtag_shift_engine;
  import jtag_shift_pkg::*;

  localparam int unsigned DIV = 2;
  localparam int unsigned PER = 2 * DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       init_done;
  logic [1:0] jtag_TCK;
  logic [1:0] jtag_TDO;
  logic       jtag_TMS, jtag_TDI, jtag_TRST, busy;
  logic       tdo_dly = 1'b0;
`ifdef JTAG_SHIFT_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  always @(negedge clk) tdo_dly <= jtag_TDI;
  assign jtag_TDO = {tdo_dly, ~tdo_dly};

  jtag_shift_if #(.MAX_BITS(64), .CHAINS(2)) hif ();

  jtag_shift_engine #(.MAX_BITS(64), .CHAINS(2), .DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .init_done (init_done),
`ifdef JTAG_SHIFT_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .host      (hif.master),
    .jtag_TCK  (jtag_TCK),
    .jtag_TMS  (jtag_TMS),
    .jtag_TDI  (jtag_TDI),
    .jtag_TRST (jtag_TRST),
    .jtag_TDO  (jtag_TDO),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    hif.rsp_ready = 1'b1;
    step();
    hif.rsp_ready = 1'b0;
  endtask

  // Issues one command, then walks the waveform cycle by cycle until rsp_valid.
  task automatic run_cmd(input jtag_cmd_t c, input int unsigned eff,
                         output int unsigned lat, output int unsigned rises,
                         output int unsigned werr, output logic [63:0] tdo,
                         output logic ab);
    logic        prev, sel, oth, exp_tck;
    int unsigned j;
    hif.cmd_tms   = c.tms;
    hif.cmd_tdi   = c.tdi;
    hif.cmd_len   = c.len;
    hif.cmd_chain = c.chain;
    hif.cmd_valid = 1'b1;
    step();
    hif.cmd_valid = 1'b0;
    lat = 1; rises = 0; werr = 0; prev = 1'b0; j = 0;
    forever begin
      sel = jtag_TCK[c.chain];
      oth = jtag_TCK[~c.chain];
      if (j < PER * eff) begin
        exp_tck = ((j % PER) >= DIV);
        if (jtag_TMS !== c.tms[j / PER] || jtag_TDI !== c.tdi[j / PER]) werr++;
      end else begin
        exp_tck = 1'b0;
      end
      if (sel !== exp_tck || oth !== 1'b0) werr++;
      if (sel && !prev) rises++;
      prev = sel;
      if (hif.rsp_valid === 1'b1 || lat >= 600) break;
      step();
      lat++;
      j++;
    end
    tdo = hif.rsp_tdo;
    ab  = hif.rsp_aborted;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; init_done = 1'b0;
    hif.cmd_valid = 1'b0; hif.rsp_ready = 1'b0;
    hif.cmd_tms = '0; hif.cmd_tdi = '0; hif.cmd_len = '0; hif.cmd_chain = '0;
    #2 reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRST, hif.cmd_ready, hif.rsp_valid,
         hif.rsp_aborted, busy} !== 9'b00_1_0_1_0_0_0_0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 001010000",
               {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRST, hif.cmd_ready, hif.rsp_valid,
                hif.rsp_aborted, busy});
    end
    checks++;
    if (hif.rsp_tdo !== 64'h0) begin
      errors++; $display("FAIL reset_tdo: got %h expected 0", hif.rsp_tdo);
    end
    reset_n = 1'b1;
    init_done = 1'b1;
    step(); step();
    checks++;
    if ({jtag_TRST, hif.cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL init_only: trst/ready got %b expected 10", {jtag_TRST, hif.cmd_ready});
    end
    enable = 1'b1;
    step();
    checks++;
    if ({jtag_TRST, hif.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL run_rise: trst/ready got %b expected 01", {jtag_TRST, hif.cmd_ready});
    end
  endtask

  task automatic test_shift();
    jtag_cmd_t   c;
    int unsigned lat, rises, werr;
    logic [63:0] tdo;
    logic        ab;
    c.tms = 64'h01; c.tdi = 64'hFFFF_0000_0000_00A5; c.len = 7'd8; c.chain = 1'b1;
    run_cmd(c, 8, lat, rises, werr, tdo, ab);
    checks++; if (lat !== 33) begin errors++; $display("FAIL shift_lat: got %0d expected 33", lat); end
    checks++; if (tdo !== 64'hA5) begin errors++; $display("FAIL shift_tdo: got %h expected a5", tdo); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL shift_abort: got %b expected 0", ab); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL shift_rises: got %0d expected 8", rises); end
    checks++; if (werr !== 0) begin errors++; $display("FAIL shift_wave: %0d bad cycles expected 0", werr); end
    drain();
    checks++;
    if ({hif.rsp_valid, hif.cmd_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL shift_drain: valid/ready/busy got %b expected 010",
                         {hif.rsp_valid, hif.cmd_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    jtag_cmd_t   c;
    int unsigned lat, rises, werr;
    logic [63:0] tdo;
    logic        ab;
    c.tms = 64'h4; c.tdi = 64'h6; c.len = 7'd3; c.chain = 1'b0;
    run_cmd(c, 3, lat, rises, werr, tdo, ab);
    checks++; if (lat !== 13) begin errors++; $display("FAIL b2b_lat: got %0d expected 13", lat); end
    checks++; if (tdo !== 64'h1) begin errors++; $display("FAIL b2b_tdo: got %h expected 1", tdo); end
    checks++; if (rises !== 3) begin errors++; $display("FAIL b2b_rises: got %0d expected 3", rises); end
    checks++; if (werr !== 0) begin errors++; $display("FAIL b2b_wave: %0d bad cycles expected 0", werr); end
    drain();
  endtask

  task automatic test_len_zero();
    jtag_cmd_t   c;
    int unsigned lat, rises, werr;
    logic [63:0] tdo;
    logic        ab;
    c.tms = 64'hFF; c.tdi = 64'hFF; c.len = 7'd0; c.chain = 1'b1;
    run_cmd(c, 0, lat, rises, werr, tdo, ab);
    checks++; if (lat !== 1) begin errors++; $display("FAIL len0_lat: got %0d expected 1", lat); end
    checks++; if (tdo !== 64'h0) begin errors++; $display("FAIL len0_tdo: got %h expected 0", tdo); end
    checks++; if (rises !== 0) begin errors++; $display("FAIL len0_rises: got %0d expected 0", rises); end
    checks++; if (werr !== 0) begin errors++; $display("FAIL len0_wave: %0d bad cycles expected 0", werr); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL len0_abort: got %b expected 0", ab); end
    drain();
  endtask

  task automatic test_max_len();
    jtag_cmd_t   c;
    int unsigned lat, rises, werr;
    logic [63:0] tdo;
    logic        ab;
    c.tms = 64'h0; c.tdi = 64'hDEAD_BEEF_0123_4567; c.len = 7'd69; c.chain = 1'b1;
    run_cmd(c, 64, lat, rises, werr, tdo, ab);
    checks++; if (lat !== 257) begin errors++; $display("FAIL max_lat: got %0d expected 257", lat); end
    checks++; if (tdo !== 64'hDEAD_BEEF_0123_4567) begin
      errors++; $display("FAIL max_tdo: got %h expected deadbeef01234567", tdo);
    end
    checks++; if (rises !== 64) begin errors++; $display("FAIL max_rises: got %0d expected 64", rises); end
    checks++; if (werr !== 0) begin errors++; $display("FAIL max_wave: %0d bad cycles expected 0", werr); end
    drain();
  endtask

  task automatic test_abort();
    int unsigned rises;
    logic        prev;
    hif.cmd_tms = 64'h0; hif.cmd_tdi = 64'h0A35; hif.cmd_len = 7'd16; hif.cmd_chain = 1'b0;
    hif.cmd_valid = 1'b1;
    step();
    hif.cmd_valid = 1'b0;
    rises = 0;
    prev  = jtag_TCK[0];
    for (int n = 0; n < 200 && rises < 5; n++) begin
      step();
      if (jtag_TCK[0] && !prev) rises++;
      prev = jtag_TCK[0];
    end
    checks++; if (rises !== 5) begin errors++; $display("FAIL abort_reach: rises %0d expected 5", rises); end
    enable = 1'b0;
    step();
    checks++;
    if ({hif.rsp_valid, hif.rsp_aborted, jtag_TRST, jtag_TCK} !== 5'b111_00) begin
      errors++; $display("FAIL abort_state: valid/aborted/trst/tck got %b expected 11100",
                         {hif.rsp_valid, hif.rsp_aborted, jtag_TRST, jtag_TCK});
    end
    checks++;
    if (hif.rsp_tdo !== 64'h0A) begin
      errors++; $display("FAIL abort_tdo: got %h expected 0a", hif.rsp_tdo);
    end
    step();
    checks++;
    if ({hif.rsp_valid, hif.rsp_tdo[4:0], jtag_TCK} !== 8'b1_01010_00) begin
      errors++; $display("FAIL abort_hold: valid/tdo/tck got %b expected 10101000",
                         {hif.rsp_valid, hif.rsp_tdo[4:0], jtag_TCK});
    end
    drain();
    checks++;
    if ({busy, hif.cmd_ready, jtag_TRST, hif.rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL abort_disabled: busy/ready/trst/valid got %b expected 0010",
                         {busy, hif.cmd_ready, jtag_TRST, hif.rsp_valid});
    end
    enable = 1'b1;
    step();
    checks++;
    if ({jtag_TRST, hif.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL abort_rerun: trst/ready got %b expected 01", {jtag_TRST, hif.cmd_ready});
    end
  endtask

`ifdef JTAG_SHIFT_LOOPBACK_EN
  task automatic test_loopback();
    jtag_cmd_t   c;
    int unsigned lat, rises, werr;
    logic [63:0] tdo;
    logic        ab;
    loopback = 1'b1;
    c.tms = 64'h0; c.tdi = 64'h3C; c.len = 7'd8; c.chain = 1'b0;
    run_cmd(c, 8, lat, rises, werr, tdo, ab);
    checks++; if (tdo !== 64'h3C) begin errors++; $display("FAIL loop_tdo: got %h expected 3c", tdo); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL loop_rises: got %0d expected 8", rises); end
    drain();
    loopback = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_shift();
    test_back_to_back();
    test_len_zero();
    test_max_len();
    test_abort();
`ifdef JTAG_SHIFT_LOOPBACK_EN
    test_loopback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
